// File: rtl/maj_fold_stim_checker.sv
// Stimulus generator and response checker for an N-input majority block.
// Each vector is applied, settled, sampled, then popcounted CHUNK bits per cycle and compared.
module maj_fold_stim_checker #(
    parameter int N      = 49,
    parameter int CHUNK  = 7,
    parameter int SETTLE = 1,
    parameter int PW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  seed,
    input  logic [31:0]   num_vec,
    input  logic          y_dut,
    output logic [N-1:0]  x,
    output logic          busy,
    output logic          done,
    output logic [31:0]   vec_count,
    output logic [31:0]   mismatch_count,
    output logic          first_fail_valid,
    output logic [N-1:0]  first_fail_vec,
    output logic          first_fail_ref
);

    localparam int NCH = (N + CHUNK - 1) / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PW-1:0] THRESH = PW'((N + 1) / 2);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_COUNT,
        S_CMP,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         remaining;
    logic [SW-1:0]       settle_cnt;
    logic                ysamp;
    logic [PW-1:0]       acc;
    logic [KW-1:0]       k;
    logic [NCH*CHUNK-1:0] x_pad;
    logic [CHUNK-1:0]    chunk;
    logic [PW-1:0]       chunk_pop;
    logic                ref_bit;

    function automatic logic [PW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Bits beyond N in the last chunk read as zero.
    always_comb begin
        x_pad         = '0;
        x_pad[N-1:0]  = x;
        chunk         = x_pad[int'(k)*CHUNK +: CHUNK];
        chunk_pop     = popcnt(chunk);
        ref_bit       = (acc >= THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (num_vec == 32'd0) ? S_DONE : S_APPLY;
            S_APPLY:        if (settle_cnt == S_LAST) state_nxt = S_COUNT;
            S_COUNT:        if (k == K_LAST) state_nxt = S_CMP;
            S_CMP:          state_nxt = (remaining == 32'd1) ? S_DONE : S_APPLY;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_APPLY) || (state == S_COUNT) || (state == S_CMP);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x                <= '0;
            remaining        <= '0;
            settle_cnt       <= '0;
            ysamp            <= 1'b0;
            acc              <= '0;
            k                <= '0;
            vec_count        <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_ref   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x                <= seed;
                        remaining        <= num_vec;
                        settle_cnt       <= '0;
                        vec_count        <= '0;
                        mismatch_count   <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        first_fail_ref   <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (settle_cnt == S_LAST) begin
                        ysamp <= y_dut;
                        acc   <= '0;
                        k     <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_COUNT: begin
                    acc <= acc + chunk_pop;
                    k   <= k + KW'(1);
                end
                S_CMP: begin
                    vec_count <= vec_count + 32'd1;
                    // Case inequality so an undriven/X response counts as a failure.
                    if (ysamp !== ref_bit) begin
                        mismatch_count <= sat_inc(mismatch_count);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= x;
                            first_fail_ref   <= ref_bit;
                        end
                    end
                    x          <= x + N'(1);
                    remaining  <= remaining - 32'd1;
                    settle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/maj_fold_stim_checker.md
Name: maj_fold_stim_checker

Overview:
- Sequential stimulus generator and response checker for the N-input combinational majority block (ports x0..x(N-1), y0).
- Drives one input vector at a time and waits for the DUT output to settle.
- Computes the reference majority with a folded, chunk-per-cycle popcount, compares it against the sampled y0, and accumulates pass/fail statistics.
- Replaces exhaustive-loop benches with a synthesizable, on-chip self-check of arbitrary vector ranges.

Parameters:
- N, 49, majority width; must be odd.
- CHUNK, 7, bits popcounted per cycle; NCH = ceil(N/CHUNK) = 7.
- SETTLE, 1, cycles x is held before y_dut is sampled; must be >= 1.
- PW, $clog2(N+1) = 6, popcount accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a run (honoured only in IDLE or DONE).
- seed  in  N  first vector applied.
- num_vec  in  32  number of vectors in the run.
- y_dut  in  1  y0 from the majority DUT.
- x  out  N  vector driven to the DUT (x[i] -> xi).
- busy  out  1  high in APPLY/COUNT/CMP.
- done  out  1  high in DONE.
- vec_count  out  32  vectors compared so far.
- mismatch_count  out  32  mismatches so far; saturates at 0xFFFFFFFF.
- first_fail_valid  out  1  a mismatch has been captured.
- first_fail_vec  out  N  vector of the first mismatch.
- first_fail_ref  out  1  reference value at the first mismatch.

Behaviour:
- Reset (async) clears all outputs and state to 0 and forces IDLE. Applies immediately, including mid-run.
- All registers update on the rising clk edge.
- IDLE / DONE on start:
  - latch seed into x and num_vec into remaining;
  - clear vec_count, mismatch_count, first_fail_*.
  - If num_vec == 0, go to DONE; otherwise go to APPLY.
- start is ignored in APPLY/COUNT/CMP.
- APPLY: x held stable for SETTLE cycles. On the last APPLY cycle:
  - y_dut is registered into ysamp;
  - acc <= 0, chunk index k <= 0;
  - go to COUNT.
- COUNT: NCH cycles. Each cycle: acc <= acc + popcount(x[k*CHUNK +: CHUNK]), with bits >= N treated as 0; k <= k + 1. After k = NCH-1, go to CMP.
- CMP: one cycle.
  - ref = (acc >= (N+1)/2), i.e. >= 25 for N = 49.
  - vec_count <= vec_count + 1.
  - If ysamp != ref: mismatch_count increments (saturating). If first_fail_valid was 0, capture first_fail_vec <= x and first_fail_ref <= ref, and set first_fail_valid <= 1.
  - Then x <= x + 1 (mod 2^N; all-ones wraps to 0) and remaining <= remaining - 1.
  - If remaining was 1, go to DONE; else go to APPLY.
- Per-vector cost is SETTLE + NCH + 1 cycles (9 at defaults).
  - With start sampled at edge t, done rises at edge t + 9*num_vec.
  - With num_vec = 0, done rises at edge t.
- DONE: done = 1. Counters and x hold until the next start or rst.
- x changes only on an IDLE/DONE start or at CMP exit. y_dut is sampled only at the end of APPLY.
- y_dut being X is treated as a mismatch: compare with !==, not-equal in simulation.

Test Plan:
- Correct DUT model, seed = 0, num_vec = 4 → done 36 cycles after start, vec_count = 4, mismatch_count = 0, first_fail_valid = 0, final x = 4.
- Threshold: correct DUT, seed = 0x1FFFFFE (24 ones), num_vec = 2 → ref 0 then ref 1 (0x1FFFFFF, 25 ones), mismatch_count = 0.
- Stuck-at-0 DUT, seed = 0x1FFFFFE, num_vec = 3 → mismatch_count = 1, first_fail_vec = 0x1FFFFFF, first_fail_ref = 1, vec_count = 3.
- Wrap: seed = all-ones (49 ones), num_vec = 2, correct DUT → refs 1 then 0, x = 1 at DONE, mismatch_count = 0.
- num_vec = 0 → done at the first edge after start, all counts 0.
- Control robustness:
  - a start pulse during busy is ignored (run length unchanged);
  - rst asserted mid-COUNT → x, counters, busy, done read 0 immediately;
  - after rst deasserts, a fresh start with num_vec = 1 completes in 9 cycles.
